// File: rtl/pm_loader_if.sv
// Nibble stream and program-memory write bus between a frame source and pm_loader.
interface pm_loader_if #(
   parameter int ADDR_W = 8
);
   logic [3:0]        nib_in;
   logic              nib_valid;
   logic              nib_ready;
   logic [ADDR_W-1:0] pm_addr;
   logic [7:0]        pm_wdata;
   logic              pm_wren;

   modport master (
      output nib_in, nib_valid,
      input  nib_ready, pm_addr, pm_wdata, pm_wren
   );

   modport slave (
      input  nib_in, nib_valid,
      output nib_ready, pm_addr, pm_wdata, pm_wren
   );
endinterface

// File: rtl/pm_loader.sv
// Loads a length/data/checksum frame from a nibble stream into program memory
// while holding the CPU in reset; releases the CPU only after a good checksum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no session, CPU released, waiting for start
// LEN_HI  | expecting high nibble of length byte
// LEN_LO  | expecting low nibble of length byte, loads byte counter
// DAT_HI  | expecting high nibble of a data byte
// DAT_LO  | expecting low nibble of a data byte, schedules the write
// SUM_HI  | expecting high nibble of checksum byte
// SUM_LO  | expecting low nibble of checksum byte, compares running sum
// ERR     | failed or aborted session, CPU still held, waits for start
module pm_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   pm_loader_if.slave   bus,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic         error
);

   localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DAT_HI,
      S_DAT_LO,
      S_SUM_HI,
      S_SUM_LO,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        hi_q, hi_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              wren_q, wren_d;
   logic              done_q, done_d;

   logic              in_session;
   logic              xfer;
   logic [7:0]        rx_byte;

   always_comb begin
      in_session = (state_q != S_IDLE) && (state_q != S_ERR);
      xfer       = in_session && bus.nib_valid;
      rx_byte    = {hi_q, bus.nib_in};
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      wdata_d = wdata_q;
      wren_d  = 1'b0;
      done_d  = 1'b0;

      // The address advances only after its write strobe has been presented.
      if (wren_q) begin
         addr_d = addr_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_HI;
               cnt_d   = '0;
               addr_d  = BASE;
               sum_d   = '0;
            end
         end
         S_LEN_HI, S_DAT_HI, S_SUM_HI: begin
            if (xfer) begin
               hi_d    = bus.nib_in;
               state_d = (state_q == S_LEN_HI) ? S_LEN_LO :
                         (state_q == S_DAT_HI) ? S_DAT_LO : S_SUM_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               cnt_d   = (rx_byte == 8'd0) ? FULL_CNT : CNT_W'(rx_byte);
               state_d = S_DAT_HI;
            end
         end
         S_DAT_LO: begin
            if (xfer) begin
               wren_d  = 1'b1;
               wdata_d = rx_byte;
               sum_d   = sum_q + rx_byte;
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == CNT_W'(1)) ? S_SUM_HI : S_DAT_HI;
            end
         end
         S_SUM_LO: begin
            if (xfer) begin
               if (rx_byte == sum_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over a nibble accepted in the same cycle.
      if (abort && in_session) begin
         state_d = S_ERR;
         wren_d  = 1'b0;
         wdata_d = wdata_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         cnt_q   <= '0;
         addr_q  <= BASE;
         sum_q   <= '0;
         wdata_q <= '0;
         wren_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         wdata_q <= wdata_d;
         wren_q  <= wren_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      bus.nib_ready = in_session;
      bus.pm_addr   = addr_q;
      bus.pm_wdata  = wdata_q;
      bus.pm_wren   = wren_q;
      busy          = in_session;
      cpu_hold      = in_session || (state_q == S_ERR);
      error         = (state_q == S_ERR);
      done          = done_q;
   end

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: two instances (base 0x00 and 0xFE) share one nibble stream;
// expected writes and outcomes come from the frame contents via plain arithmetic.
module tb_pm_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [3:0] nib_in;
   logic       nib_valid;

   logic busy0, cpu_hold0, done0, error0;
   logic busy1, cpu_hold1, done1, error1;

   int vectors    = 0;
   int miscompares = 0;
   int done_cnt   = 0;
   int stall_cnt  = 0;
   int wren_run_err = 0;
   bit rand_start = 0;
   bit wren_prev  = 0;

   logic [7:0]  frame[$];
   logic [15:0] got0[$];
   logic [15:0] got1[$];

   pm_loader_if #(.ADDR_W(8)) if0 ();
   pm_loader_if #(.ADDR_W(8)) if1 ();

   assign if0.nib_in    = nib_in;
   assign if0.nib_valid = nib_valid;
   assign if1.nib_in    = nib_in;
   assign if1.nib_valid = nib_valid;

   pm_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(if0),
      .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0)
   );

   pm_loader #(.ADDR_W(8), .BASE_ADDR('hFE)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(if1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (if0.pm_wren === 1'b1) got0.push_back({if0.pm_addr, if0.pm_wdata});
      if (if1.pm_wren === 1'b1) got1.push_back({if1.pm_addr, if1.pm_wdata});
      if (done0 === 1'b1) done_cnt++;
      if (if0.pm_wren === 1'b1 && wren_prev) wren_run_err++;
      wren_prev = (if0.pm_wren === 1'b1);
   end

   function automatic logic [7:0] model_sum();
      logic [7:0] s = 8'd0;
      foreach (frame[i]) s = s + frame[i];
      return s;
   endfunction

   task automatic send_nib(input logic [3:0] n, input int gap);
      int t = 0;
      repeat (gap) begin
         nib_valid = 1'b0;
         start = rand_start ? ($urandom_range(0, 2) == 0) : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      nib_in = n;
      nib_valid = 1'b1;
      while (if0.nib_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         vectors++;
         miscompares++;
         $display("FAIL nib_timeout: nib_ready stayed %b, required 1", if0.nib_ready);
      end
      stall_cnt += t;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gapmax);
      send_nib(b[7:4], $urandom_range(0, gapmax));
      send_nib(b[3:0], $urandom_range(0, gapmax));
   endtask

   task automatic send_frame(input logic [7:0] len_field, input logic [7:0] sum_tx,
                             input int gapmax);
      send_byte(len_field, gapmax);
      foreach (frame[i]) send_byte(frame[i], gapmax);
      send_byte(sum_tx, gapmax);
      nib_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy0 !== 1'b1 || cpu_hold0 !== 1'b1 || error0 !== 1'b0 || if0.nib_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL start_entry: busy=%b hold=%b err=%b rdy=%b, required 1 1 0 1",
                  busy0, cpu_hold0, error0, if0.nib_ready);
      end
   endtask

   // Called at the negedge right after the checksum transfer.
   task automatic check_frame(input bit ok, input int done_before);
      logic [15:0] e0, e1;
      logic [7:0]  a1;
      int n;
      vectors++;
      if (done0 !== ok || done1 !== ok || busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: done0=%b done1=%b busy=%b, required done=%b busy=0",
                  done0, done1, busy0, ok);
      end
      @(negedge clk);
      vectors++;
      if (got0.size() != frame.size() || got1.size() != frame.size()) begin
         miscompares++;
         $display("FAIL write_count: got %0d/%0d writes, required %0d",
                  got0.size(), got1.size(), frame.size());
      end
      n = (got0.size() < got1.size()) ? got0.size() : got1.size();
      if (n > frame.size()) n = frame.size();
      for (int i = 0; i < n; i++) begin
         a1 = 8'hFE + 8'(i);
         e0 = {8'(i), frame[i]};
         e1 = {a1, frame[i]};
         vectors++;
         if (got0[i] !== e0 || got1[i] !== e1) begin
            miscompares++;
            $display("FAIL write_%0d: got %h/%h, required %h/%h", i, got0[i], got1[i], e0, e1);
         end
      end
      vectors++;
      if (error0 !== !ok || error1 !== !ok || cpu_hold0 !== !ok || cpu_hold1 !== !ok ||
          busy0 !== 1'b0 || done0 !== 1'b0 || (done_cnt - done_before) != int'(ok)) begin
         miscompares++;
         $display("FAIL frame_status: err=%b/%b hold=%b/%b busy=%b done=%b pulses=%0d, required err=%b hold=%b busy=0 done=0 pulses=%0d",
                  error0, error1, cpu_hold0, cpu_hold1, busy0, done0, done_cnt - done_before,
                  !ok, !ok, int'(ok));
      end
      got0.delete();
      got1.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if (if0.nib_ready !== 1'b0 || if0.pm_wren !== 1'b0 || if0.pm_addr !== 8'h00 ||
          if0.pm_wdata !== 8'h00 || if1.pm_addr !== 8'hFE || cpu_hold0 !== 1'b0 ||
          busy0 !== 1'b0 || done0 !== 1'b0 || error0 !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: rdy=%b wren=%b addr=%h/%h wdata=%h hold=%b busy=%b done=%b err=%b, required 0 0 00/fe 00 0 0 0 0",
                  tag, if0.nib_ready, if0.pm_wren, if0.pm_addr, if1.pm_addr, if0.pm_wdata,
                  cpu_hold0, busy0, done0, error0);
      end
   endtask

   task automatic test_reset();
      #3;
      check_reset_outputs("reset_state");
      @(negedge clk);
      reset = 1'b0;
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (busy0 !== 1'b0 || error0 !== 1'b0 || cpu_hold0 !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_in_idle: busy=%b err=%b hold=%b, required 0 0 0",
                  busy0, error0, cpu_hold0);
      end
   endtask

   task automatic test_basic();
      int db = done_cnt;
      frame = '{8'hA1, 8'h22, 8'h33};
      do_start();
      send_frame(8'd3, 8'hF6, 0);
      check_frame(1'b1, db);
   endtask

   task automatic test_bad_sum();
      int db = done_cnt;
      frame = '{8'hA1, 8'h22, 8'h33};
      do_start();
      send_frame(8'd3, 8'h00, 1);
      check_frame(1'b0, db);
      do_start();
      db = done_cnt;
      frame = '{8'h5C, 8'h07};
      send_frame(8'd2, model_sum(), 0);
      check_frame(1'b1, db);
   endtask

   task automatic test_wrap();
      int db = done_cnt;
      frame = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_start();
      send_frame(8'd4, 8'h0A, 0);
      check_frame(1'b1, db);
   endtask

   task automatic test_back_to_back();
      int db = done_cnt;
      int st = stall_cnt;
      int wr = wren_run_err;
      time t0, t1;
      frame.delete();
      for (int i = 0; i < 256; i++) frame.push_back(8'(i));
      do_start();
      t0 = $time;
      send_frame(8'd0, 8'h80, 0);
      t1 = $time;
      vectors++;
      if ((t1 - t0) / 10 != 516 || stall_cnt != st) begin
         miscompares++;
         $display("FAIL no_stall: %0d cycles (%0d stalls), required 516 cycles 0 stalls",
                  (t1 - t0) / 10, stall_cnt - st);
      end
      vectors++;
      if (wren_run_err != wr) begin
         miscompares++;
         $display("FAIL wren_single: %0d multi-cycle strobes, required 0", wren_run_err - wr);
      end
      check_frame(1'b1, db);
   endtask

   task automatic test_random();
      int db;
      int len;
      bit bad;
      logic [7:0] s;
      rand_start = 1;
      for (int f = 0; f < 8; f++) begin
         db = done_cnt;
         len = $urandom_range(1, 40);
         frame.delete();
         for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
         bad = ($urandom_range(0, 3) == 0);
         s = model_sum();
         if (bad) s = s ^ 8'($urandom_range(1, 255));
         do_start();
         send_frame(8'(len), s, 2);
         check_frame(!bad, db);
      end
      rand_start = 0;
   endtask

   task automatic test_abort();
      frame = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_start();
      send_byte(8'd4, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_nib(4'h3, 0);
      vectors++;
      if (if0.nib_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_setup: nib_ready=%b, required 1", if0.nib_ready);
      end
      nib_in = 4'h3;
      nib_valid = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      nib_valid = 1'b0;
      vectors++;
      if (error0 !== 1'b1 || busy0 !== 1'b0 || cpu_hold0 !== 1'b1 || if0.nib_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_err: err=%b busy=%b hold=%b rdy=%b, required 1 0 1 0",
                  error0, busy0, cpu_hold0, if0.nib_ready);
      end
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (got0.size() != 2 || error0 !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_writes: %0d writes err=%b, required 2 writes err=1",
                  got0.size(), error0);
      end else begin
         vectors++;
         if (got0[0] !== 16'h0011 || got0[1] !== 16'h0122) begin
            miscompares++;
            $display("FAIL abort_data: got %h %h, required 0011 0122", got0[0], got0[1]);
         end
      end
      got0.delete();
      got1.delete();
   endtask

   task automatic test_async_reset();
      do_start();
      send_byte(8'd5, 0);
      send_byte(8'h9D, 0);
      #2 reset = 1'b1;
      #1 check_reset_outputs("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (got0.size() != 1 || busy0 !== 1'b0 || if0.nib_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_discard: %0d writes busy=%b rdy=%b, required 1 0 0",
                  got0.size(), busy0, if0.nib_ready);
      end
      got0.delete();
      got1.delete();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      nib_in = 4'h0;
      nib_valid = 1'b0;
      test_reset();
      test_basic();
      test_bad_sum();
      test_wrap();
      test_back_to_back();
      test_random();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
